// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte outputs of the 8N1 receiver.
//   rx         - asynchronous serial line into the receiver (idles high)
//   data_out   - last correctly framed byte
//   data_valid - one-cycle strobe when data_out updates
//   frame_err  - one-cycle strobe when a stop bit samples low
// The master modport is the receiver side; slave is the line driver / byte consumer.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;

    modport master (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a counter-based bit timer.
//   clk - system clock, all state on posedge
//   rst - synchronous active-high reset
//   bus - uart_rx_if.master: rx in; data_out, data_valid, frame_err out
// rx is double-flopped; the FSM only looks at the second flop. Each bit is
// sampled once at its centre and shifted in LSB-first.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned H    = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(H - 1);
    localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], bus.rx};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    // Start bit still low at its centre: real frame, else a glitch.
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitM1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitM1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        // Back to idle mid stop bit so a following start bit is caught.
                        state_d      = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                // A held-low line must go high before another frame can start.
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
// Stimulus changes on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx;
    logic clk;
    logic rst;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pulse monitor.
    int         vcnt = 0;
    int         vcyc = -1;
    logic [7:0] vdata = 8'h00;
    int         fcnt = 0;
    int         fcyc = -1;
    int         overlap = 0;
    int         consec = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            vcnt  = vcnt + 1;
            vcyc  = cyc;
            vdata = bus.data_out;
        end
        if (bus.frame_err) begin
            fcnt = fcnt + 1;
            fcyc = cyc;
        end
        if (bus.data_valid && bus.frame_err) overlap = overlap + 1;
        if ((bus.data_valid && prev_v) || (bus.frame_err && prev_f)) consec = consec + 1;
        prev_v = bus.data_valid;
        prev_f = bus.frame_err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge exactly 160 cycles later.
    task automatic send(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (16) @(negedge clk);
        end
        bus.rx = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int t0, t1, v0, f0;

    initial begin
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", int'(bus.data_out), 32'h00);
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_ferr", int'(bus.frame_err), 0);
        rst = 1'b0;
        idle(40);

        // 0xA5, valid at E0+152 (E0 is two edges after the first low sample).
        send(8'hA5, 1'b1, t0);
        check("a5_count", vcnt, 1);
        check("a5_data", int'(vdata), 32'hA5);
        check("a5_time", vcyc, t0 + 155);
        check("a5_ferr", fcnt, 0);
        idle(40);

        // 0x00 then 0xFF with no idle gap.
        send(8'h00, 1'b1, t0);
        check("b2b0_data", int'(vdata), 32'h00);
        check("b2b0_time", vcyc, t0 + 155);
        send(8'hFF, 1'b1, t1);
        check("b2b1_data", int'(vdata), 32'hFF);
        check("b2b1_gap", vcyc - (t0 + 155), 160);
        check("b2b_count", vcnt, 3);
        idle(40);

        // Short low glitch is rejected at the start-bit centre.
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(60);
        check("glitch_valid", vcnt, 3);
        check("glitch_ferr", fcnt, 0);
        check("glitch_data", int'(bus.data_out), 32'hFF);

        // Good 0x11, then 0x3C with a low stop bit and a long break.
        send(8'h11, 1'b1, t0);
        check("g11_data", int'(vdata), 32'h11);
        send(8'h3C, 1'b0, t0);
        repeat (40) @(negedge clk);
        check("ferr_count", fcnt, 1);
        check("ferr_time", fcyc, t0 + 155);
        check("ferr_valid", vcnt, 5 - 1);
        check("ferr_data", int'(bus.data_out), 32'h11);
        idle(40);
        check("break_noframe", vcnt + fcnt, 5);
        send(8'h5A, 1'b1, t0);
        check("after_brk_data", int'(vdata), 32'h5A);
        check("after_brk_time", vcyc, t0 + 155);
        idle(40);

        // Reset in the middle of bit 7 of 0xC3.
        v0 = vcnt;
        f0 = fcnt;
        bus.rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            bus.rx = (8'hC3 >> i) & 8'h01;
            repeat (16) @(negedge clk);
        end
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", int'(bus.data_out), 32'h00);
        check("mid_rst_valid", int'(bus.data_valid), 0);
        check("mid_rst_ferr", int'(bus.frame_err), 0);
        idle(60);
        check("mid_rst_novalid", vcnt, v0);
        check("mid_rst_noferr", fcnt, f0);
        send(8'h7E, 1'b1, t0);
        check("post_rst_data", int'(vdata), 32'h7E);
        check("post_rst_time", vcyc, t0 + 155);
        idle(10);

        // Reset with no clock edge yet has no effect.
        rst = 1'b1;
        #1;
        check("sync_rst_hold", int'(bus.data_out), 32'h7E);
        @(posedge clk);
        #1;
        check("sync_rst_apply", int'(bus.data_out), 32'h00);
        rst = 1'b0;
        idle(4);

        check("pulse_overlap", overlap, 0);
        check("pulse_consec", consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
